// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable-frame UART transmitter; UART_TX_FIFO_EN selects a FIFO store, otherwise a single holding register
module uart_tx_cfg #(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_BITS-1:0]            tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            txd
);

  localparam int CW       = $clog2(FIFO_DEPTH+1);
  localparam int BCW      = $clog2(CLK_PER_BIT);
  localparam int IW       = $clog2(DATA_BITS);
  localparam int LAST_BIT = (CLK_PER_BIT * 9) / 10;
`ifdef UART_TX_FIFO_EN
  localparam int CAPACITY = FIFO_DEPTH;
`else
  localparam int CAPACITY = 1;
`endif

  localparam logic [BCW-1:0] BIT_RELOAD  = BCW'(CLK_PER_BIT - 1);
  localparam logic [BCW-1:0] LAST_RELOAD = BCW'(LAST_BIT - 1);
  localparam logic [IW-1:0]  IDX_LAST    = IW'(DATA_BITS - 1);
  localparam logic [CW-1:0]  CAP_W       = CW'(CAPACITY);
  localparam logic [CW-1:0]  ONE_W       = CW'(1);

  // Stop phase entry: two-stop frames start with a full-length bit,
  // single-stop frames go straight to the shortened final bit.
  localparam logic [BCW-1:0] STOP_RELOAD = (STOP_BITS == 2) ? BIT_RELOAD : LAST_RELOAD;
  localparam logic           STOP_FIRST  = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;
  logic [CW-1:0]        count_q;

  state_t               state_q, state_d;
  logic [BCW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop_first_q, stop_first_d;
  logic                 txd_d;
  logic                 busy_d;
  logic                 bit_end;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot
  assign tx_ready   = (count_q != CAP_W);
  assign push       = tx_valid && tx_ready;
  assign pop        = (state_q == S_IDLE) && (count_q != '0);
  assign fifo_count = count_q;
  assign bit_end    = (cnt_q == '0);

  // Occupancy count: push and pop together leave it unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + ONE_W;
    end else if (pop && !push) begin
      count_q <= count_q - ONE_W;
    end
  end

`ifdef UART_TX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;

  // Storage array; contents are only read behind a nonzero count, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Read/write pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign head = mem[rd_ptr];
`else
  logic [DATA_BITS-1:0] hold_q;

  // Single holding register captured on the accepting edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else if (push) begin
      hold_q <= tx_data;
    end
  end

  assign head = hold_q;
`endif

  // Engine state, bit timer, shifter and registered line/busy outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      stop_first_q <= 1'b0;
      txd          <= 1'b1;
      tx_busy      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      stop_first_q <= stop_first_d;
      txd          <= txd_d;
      tx_busy      <= busy_d;
    end
  end

  // Frame sequencing: each phase reloads the bit timer at its boundary and
  // presents the next line level one edge ahead so txd stays registered
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    stop_first_d = stop_first_q;
    txd_d        = txd;

    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          state_d = S_START;
          shift_d = head;
          par_d   = (PARITY == 2) ? ~(^head) : (^head);
          cnt_d   = BIT_RELOAD;
          txd_d   = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
          cnt_d   = BIT_RELOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              txd_d   = par_q;
              cnt_d   = BIT_RELOAD;
            end else begin
              state_d      = S_STOP;
              txd_d        = 1'b1;
              cnt_d        = STOP_RELOAD;
              stop_first_d = STOP_FIRST;
            end
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
            cnt_d   = BIT_RELOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d      = S_STOP;
          txd_d        = 1'b1;
          cnt_d        = STOP_RELOAD;
          stop_first_d = STOP_FIRST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          if (stop_first_q) begin
            stop_first_d = 1'b0;
            cnt_d        = LAST_RELOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Busy rises with the start bit and falls as the engine returns to an empty idle
    busy_d = (state_d != S_IDLE) || (count_q != '0);
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - table-driven bench for uart_tx_cfg (8E1 @10 clk/bit and 7O2 @4 clk/bit instances)
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] a_data;
  logic       a_valid, a_ready, a_busy, a_txd;
  logic [2:0] a_count;
  logic [6:0] b_data;
  logic       b_valid, b_ready, b_busy, b_txd;
  logic [2:0] b_count;

`ifdef UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_cfg #(
    .CLK_PER_BIT(10), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_a (
    .clk(clk), .reset(reset), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .tx_busy(a_busy), .fifo_count(a_count), .txd(a_txd)
  );

  uart_tx_cfg #(
    .CLK_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_b (
    .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .tx_busy(b_busy), .fifo_count(b_count), .txd(b_txd)
  );

  function automatic logic get_txd(input int w);
    return (w == 0) ? a_txd : b_txd;
  endfunction

  function automatic logic get_ready(input int w);
    return (w == 0) ? a_ready : b_ready;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? a_busy : b_busy;
  endfunction

  function automatic int get_count(input int w);
    return (w == 0) ? int'(a_count) : int'(b_count);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Holds txd at lvl for len cycles, starting at the current falling edge
  task automatic seg(input int w, input logic lvl, input int len, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < len; i++) begin
      if (get_txd(w) !== lvl) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: txd wrong on %0d of %0d cycles, expected %b", name, bad, len, lvl);
    end
  endtask

  // Offers d with valid high; while not ready the data bus carries garbage
  task automatic push_word(input int w, input logic [8:0] d, output int acc);
    int n;
    n = 0;
    if (w == 0) a_valid = 1'b1; else b_valid = 1'b1;
    while (!get_ready(w) && n < 3000) begin
      if (w == 0) a_data = ~d[7:0]; else b_data = ~d[6:0];
      @(negedge clk);
      n++;
    end
    if (w == 0) a_data = d[7:0]; else b_data = d[6:0];
    chk("accept_in_time", int'(n < 3000), 1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    if (w == 0) begin a_valid = 1'b0; a_data = ~d[7:0]; end
    else begin b_valid = 1'b0; b_data = ~d[6:0]; end
  endtask

  // Full frame check from the start-bit fall through the idle cycle
  task automatic frame(input int w, input logic [8:0] d, input logic par, input bit nxt,
                       input string tag, output int fall);
    int nb, cpb, sb, lastc, n;
    nb    = (w == 0) ? 8 : 7;
    cpb   = (w == 0) ? 10 : 4;
    sb    = (w == 0) ? 1 : 2;
    lastc = (cpb * 9) / 10;
    n = 0;
    while (get_txd(w) !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    fall = cyc;
    chk({tag, "_start_seen"}, int'(n < 3000), 1);
    chk({tag, "_busy_in_start"}, int'(get_busy(w)), 1);
    seg(w, 1'b0, cpb, {tag, "_start"});
    for (int i = 0; i < nb; i++) seg(w, d[i], cpb, $sformatf("%s_d%0d", tag, i));
    seg(w, par, cpb, {tag, "_parity"});
    if (sb == 2) seg(w, 1'b1, cpb, {tag, "_stop1"});
    seg(w, 1'b1, lastc, {tag, "_stop_last"});
    chk({tag, "_idle_txd"}, int'(get_txd(w)), 1);
    chk({tag, "_idle_busy"}, int'(get_busy(w)), int'(nxt));
    @(negedge clk);
    chk({tag, "_after_idle"}, int'(get_txd(w)), nxt ? 0 : 1);
  endtask

  typedef struct {
    int         w;
    logic [8:0] d;
    logic       par;
  } vec_t;

  vec_t       vecs[11];
  logic [7:0] fill_w[6];
  logic       fill_p[6];
  int         acc_t[6];
  int         acc, fall, fall0, acc0, maxc, rdy_bad, bad, nq, t_deassert;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // instance 0: 8 data bits, even parity; instance 1: 7 data bits, odd parity
    vecs[0]  = '{0, 9'h053, 1'b0};
    vecs[1]  = '{0, 9'h0FF, 1'b0};
    vecs[2]  = '{0, 9'h000, 1'b0};
    vecs[3]  = '{0, 9'h001, 1'b1};
    vecs[4]  = '{0, 9'h0A5, 1'b0};
    vecs[5]  = '{0, 9'h080, 1'b1};
    vecs[6]  = '{0, 9'h07F, 1'b1};
    vecs[7]  = '{1, 9'h041, 1'b1};
    vecs[8]  = '{1, 9'h07F, 1'b0};
    vecs[9]  = '{1, 9'h000, 1'b1};
    vecs[10] = '{1, 9'h015, 1'b0};

    fill_w[0] = 8'h11; fill_p[0] = 1'b0;
    fill_w[1] = 8'h22; fill_p[1] = 1'b0;
    fill_w[2] = 8'h37; fill_p[2] = 1'b1;
    fill_w[3] = 8'hC8; fill_p[3] = 1'b1;
    fill_w[4] = 8'h5A; fill_p[4] = 1'b0;
    fill_w[5] = 8'hE1; fill_p[5] = 1'b0;

    reset   = 1'b1;
    a_valid = 1'b0; a_data = 8'h00;
    b_valid = 1'b0; b_data = 7'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_a_txd", int'(a_txd), 1);
    chk("rst_a_busy", int'(a_busy), 0);
    chk("rst_a_ready", int'(a_ready), 1);
    chk("rst_a_count", int'(a_count), 0);
    chk("rst_b_txd", int'(b_txd), 1);
    chk("rst_b_busy", int'(b_busy), 0);
    chk("rst_b_ready", int'(b_ready), 1);
    chk("rst_b_count", int'(b_count), 0);

    for (int k = 0; k < 11; k++) begin
      push_word(vecs[k].w, vecs[k].d, acc);
      chk($sformatf("v%0d_count_after_accept", k), get_count(vecs[k].w), 1);
      chk($sformatf("v%0d_busy_after_accept", k), int'(get_busy(vecs[k].w)), 0);
      chk($sformatf("v%0d_txd_after_accept", k), int'(get_txd(vecs[k].w)), 1);
      frame(vecs[k].w, vecs[k].d, vecs[k].par, 1'b0, $sformatf("v%0d", k), fall);
      chk($sformatf("v%0d_start_latency", k), fall - acc, 1);
    end

    maxc = 0;
    rdy_bad = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          push_word(0, {1'b0, fill_w[k]}, acc_t[k]);
        end
      end
      begin
        int f;
        for (int k = 0; k < 6; k++) begin
          frame(0, {1'b0, fill_w[k]}, fill_p[k], k < 5, $sformatf("fill%0d", k), f);
          if (k == 0) fall0 = f;
        end
      end
      begin
        repeat (800) begin
          @(negedge clk);
          if (int'(a_count) > maxc) maxc = int'(a_count);
          if (a_ready !== (int'(a_count) != CAP)) rdy_bad++;
        end
      end
    join
    chk("fill_first_pop_latency", fall0 - acc_t[0], 1);
    chk("fill_second_accept_gap", acc_t[1] - acc_t[0], (CAP > 1) ? 1 : 2);
    chk("fill_max_count", maxc, CAP);
    chk("fill_ready_vs_count", rdy_bad, 0);
    chk("fill_end_busy", int'(a_busy), 0);
    chk("fill_end_count", int'(a_count), 0);

    nq = (CAP >= 2) ? 3 : 2;
    for (int k = 0; k < nq; k++) begin
      push_word(0, 9'h0F0 + 9'(k), acc);
      if (k == 0) acc0 = acc;
    end
    while (cyc < acc0 + 46) @(negedge clk);
    chk("mid_frame_txd_bit3", int'(a_txd), 0);
    chk("mid_frame_queued", int'(a_count), nq - 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_txd", int'(a_txd), 1);
    chk("mid_reset_count", int'(a_count), 0);
    chk("mid_reset_busy", int'(a_busy), 0);
    chk("mid_reset_ready", int'(a_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (a_txd !== 1'b1 || a_busy !== 1'b0 || a_count !== 3'd0) bad++;
    end
    chk("post_reset_quiet", bad, 0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    t_deassert = cyc;
    push_word(0, 9'h053, acc);
    chk("first_accept_after_reset", acc - t_deassert, 1);
    chk("post_reset_count", int'(a_count), 1);
    frame(0, 9'h053, 1'b0, 1'b0, "post_reset", fall);
    chk("post_reset_latency", fall - acc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with configurable frame format (data width, parity, stop bits) and an input FIFO with a valid/ready handshake. It accepts words from the core and serialises them LSB-first on `txd`. Back-to-back frames are sent without software pacing. It is the next-generation replacement for the fixed 8N1 transmitter on the host-link path.

## Interface
Parameters:
- `CLK_PER_BIT`, 868: clock cycles per bit period; must be ≥ 4.
- `DATA_BITS`, 8: data bits per frame; range 5–9.
- `PARITY`, 0: parity mode; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥ 2. Used only with `UART_TX_FIFO_EN`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `tx_data` in DATA_BITS: word to transmit.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: space available; a word is accepted on any rising edge where `tx_valid && tx_ready`.
- `tx_busy` out 1: a frame is in progress or a word is queued.
- `fifo_count` out $clog2(FIFO_DEPTH+1): number of queued words, excluding the frame in flight.
- `txd` out 1: serial line; idle high.

## Operation
- Storage:
  - With `UART_TX_FIFO_EN`: FIFO of `FIFO_DEPTH` entries.
  - Without it: one holding register.
- `tx_ready = (fifo_count != capacity)`. The comparison uses the registered count, so a pop in the same cycle does not free space for a push.
- Engine states: IDLE → START → DATA → PARITY (skipped when `PARITY=0`) → STOP → IDLE.
  - IDLE, store non-empty: pop the head word, load the shifter and parity register, drive `txd=0`, enter START.
  - START: lasts CLK_PER_BIT cycles.
  - DATA: DATA_BITS periods, LSB first. Each period is CLK_PER_BIT cycles.
  - PARITY: one period.
    - Even: the bit is the XOR of all data bits.
    - Odd: the bit is the inverted XOR.
  - STOP: `txd=1`.
    - With `STOP_BITS=2`, the first stop bit is CLK_PER_BIT cycles.
    - The final stop bit is floor(CLK_PER_BIT*9/10) cycles; the shortening gives receiver clock tolerance.
    - After the final stop bit, return to IDLE.
- Bit counter: width $clog2(CLK_PER_BIT). It reloads at every bit boundary and never wraps mid-bit.
- `tx_busy = (state != IDLE) || (fifo_count != 0)`.
- Push and pop in the same cycle: `fifo_count` is unchanged and the data is preserved in order.
- `tx_data` is sampled only on the accepting edge; later changes have no effect.
- Reset, including mid-frame, forces:
  - `txd=1`, state IDLE, `fifo_count=0`, `tx_busy=0`, `tx_ready=1`;
  - all queued data is discarded.
  - The first accept is possible on the first edge after `reset` deasserts.

## Timing
- Reset values: `txd=1`, `tx_busy=0`, `tx_ready=1`, `fifo_count=0`.
- `txd`, `tx_busy` and `fifo_count` are registered. `tx_ready` is combinational from the registered count only, with no path from `tx_valid`.
- Accept at edge N with the engine IDLE:
  - the word is stored at N;
  - `txd` goes low at N+1;
  - `tx_busy` is high from N+1.
- Frame length in cycles: CLK_PER_BIT·(1 + DATA_BITS + P + STOP_BITS − 1) + floor(9·CLK_PER_BIT/10), where P = 1 if parity is enabled, else 0.
- Back-to-back frames: the engine spends exactly one IDLE cycle (`txd=1`) after the final stop bit. The next start bit begins on the following edge.
- `tx_busy` falls on the edge the engine enters IDLE with an empty store.

## Configuration
- `UART_TX_FIFO_EN`
  - Defined: FIFO of `FIFO_DEPTH` entries. `fifo_count` ranges 0..FIFO_DEPTH.
  - Undefined: a single holding register; `FIFO_DEPTH` is ignored. `fifo_count` ranges 0..1. `tx_ready` deasserts while the register is full.
  - Serial timing is identical in both builds.

## Test plan
- Even-parity frame.
  - Setup: CLK_PER_BIT=10, 8 data bits, even parity, 1 stop bit. Send 0x53.
  - Required: `txd` = 0, 1,1,0,0,1,0,1,0, parity 0, each bit 10 cycles; then stop high for 9 cycles; then 1 idle cycle. Total 109 cycles from the `txd` fall.
- Odd-parity frame with 2 stop bits.
  - Setup: CLK_PER_BIT=4, 7 data bits, odd parity, 2 stop bits. Send 0x41.
  - Required: data 1,0,0,0,0,0,1; parity bit 1; stop bits of 4 and 3 cycles.
- FIFO fill.
  - Setup: macro defined, FIFO_DEPTH=4. Push 6 words on consecutive cycles while `tx_valid` is held high.
  - Required:
    - the first word is popped at N+1;
    - `tx_ready` drops when `fifo_count`=4;
    - words go out in order with exactly 1 idle cycle between frames;
    - `tx_busy` falls after the last stop bit.
- No-FIFO build.
  - Setup: macro undefined. Push 0xA5 then 0x3C.
  - Required: the second push is accepted only after the first word is popped. Both frames are correct.
- Reset mid-frame.
  - Stimulus: assert `reset` during data bit 3 with 2 words queued.
  - Required:
    - `txd=1` and `fifo_count=0` immediately;
    - after deassert, no frame is sent until a new push.
- Handshake hold.
  - Stimulus: change `tx_data` while `tx_ready=0`.
  - Required: only the value present at the accepting edge is transmitted.
